// File: rtl/platform_bank.sv
`default_nettype none
// ============================================================================
// Module   : platform_bank
// Function : Platform store with per-frame scroll, LFSR recycle and landing scan
// Revision : 1.0 - initial release
// ============================================================================
module platform_bank #(
    parameter int          N_PLAT        = 16,
    parameter int          SCREEN_H      = 480,
    parameter int          FIELD_W       = 320,
    parameter int          PLAT_W        = 32,
    parameter int          PLAT_H        = 8,
    parameter int          PLAT_STRIDE_X = 53,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [2:0]  BROKEN_COLOR  = 3'b111,
    localparam int         IDX_W         = $clog2(N_PLAT),
    localparam int         CNT_W         = $clog2(N_PLAT + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [8:0]       scroll,
    input  logic [9:0]       doodle_x,
    input  logic [9:0]       doodle_y,
    input  logic [9:0]       doodle_size,
    input  logic             doodle_falling,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [8:0]       rd_x,
    output logic [8:0]       rd_y,
    output logic [2:0]       rd_color,
    output logic             busy,
    output logic             frame_done,
    output logic             collision,
    output logic [IDX_W-1:0] collision_idx,
    output logic [CNT_W-1:0] recycled,
    output logic             overrun
);

    localparam int RANGE     = FIELD_W - PLAT_W;
    localparam int ROW_PITCH = SCREEN_H / N_PLAT;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCROLL = 2'd1;
    localparam logic [1:0] S_SCAN   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             fc_q, fc_d, fc_dly_q, fc_dly_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [9:0]       scroll_q, scroll_d;
    logic [9:0]       dx_q, dx_d, dy_q, dy_d, ds_q, ds_d;
    logic             fall_q, fall_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [CNT_W-1:0] rec_cnt_q, rec_cnt_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic             collision_q, collision_d;
    logic [IDX_W-1:0] collision_idx_q, collision_idx_d;
    logic [CNT_W-1:0] recycled_q, recycled_d;
    logic             overrun_q, overrun_d;
    logic [8:0]       x_q [N_PLAT];
    logic [8:0]       x_d [N_PLAT];
    logic [8:0]       y_q [N_PLAT];
    logic [8:0]       y_d [N_PLAT];
    logic [2:0]       color_q [N_PLAT];
    logic [2:0]       color_d [N_PLAT];

    logic        frame_edge;
    logic        last_idx;
    logic [9:0]  scroll_sum;
    logic [9:0]  wrap_y;
    logic [15:0] lfsr_next;
    logic [8:0]  lfsr_x;
    logic [10:0] px, py, dxe, dye, dse, d_bot;
    logic        plat_hit;

    assign frame_edge = fc_q & ~fc_dly_q;
    assign last_idx   = (idx_q == IDX_W'(N_PLAT - 1));

    assign scroll_sum = {1'b0, y_q[idx_q]} + scroll_q;
    assign wrap_y     = scroll_sum - 10'(SCREEN_H);
    assign lfsr_next  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign lfsr_x     = (lfsr_next[8:0] < 9'(RANGE)) ? lfsr_next[8:0]
                                                     : lfsr_next[8:0] - 9'(RANGE);

    // Landing test is done at 11 bits so none of the sums can wrap.
    assign px       = {2'b00, x_q[idx_q]};
    assign py       = {2'b00, y_q[idx_q]};
    assign dxe      = {1'b0, dx_q};
    assign dye      = {1'b0, dy_q};
    assign dse      = {1'b0, ds_q};
    assign d_bot    = dye + dse;
    assign plat_hit = fall_q && (color_q[idx_q] != BROKEN_COLOR)
                   && (dxe < px + 11'(PLAT_W)) && (dxe + dse > px)
                   && (py <= d_bot) && (d_bot < py + 11'(PLAT_H));

    assign rd_x          = x_q[rd_idx];
    assign rd_y          = y_q[rd_idx];
    assign rd_color      = color_q[rd_idx];
    assign collision     = collision_q;
    assign collision_idx = collision_idx_q;
    assign recycled      = recycled_q;
    assign overrun       = overrun_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (frame_edge) state_d = S_SCROLL;
            S_SCROLL: if (last_idx)   state_d = S_SCAN;
            S_SCAN:   if (last_idx)   state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
    end

    always_comb begin
        fc_d            = frame_clk;
        fc_dly_d        = fc_q;
        idx_d           = idx_q;
        scroll_d        = scroll_q;
        dx_d            = dx_q;
        dy_d            = dy_q;
        ds_d            = ds_q;
        fall_d          = fall_q;
        lfsr_d          = lfsr_q;
        rec_cnt_d       = rec_cnt_q;
        hit_d           = hit_q;
        hit_idx_d       = hit_idx_q;
        collision_d     = collision_q;
        collision_idx_d = collision_idx_q;
        recycled_d      = recycled_q;
        overrun_d       = overrun_q;
        x_d             = x_q;
        y_d             = y_q;
        color_d         = color_q;

        if (frame_edge && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_edge) begin
                    scroll_d  = ({1'b0, scroll} > 10'(SCREEN_H - 1)) ? 10'(SCREEN_H - 1)
                                                                     : {1'b0, scroll};
                    dx_d      = doodle_x;
                    dy_d      = doodle_y;
                    ds_d      = doodle_size;
                    fall_d    = doodle_falling;
                    idx_d     = '0;
                    rec_cnt_d = '0;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                end
            end
            S_SCROLL: begin
                if (scroll_sum >= 10'(SCREEN_H)) begin
                    y_d[idx_q]     = wrap_y[8:0];
                    x_d[idx_q]     = lfsr_x;
                    color_d[idx_q] = lfsr_next[15:13];
                    lfsr_d         = lfsr_next;
                    rec_cnt_d      = rec_cnt_q + CNT_W'(1);
                end else begin
                    y_d[idx_q] = scroll_sum[8:0];
                end
                idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
            end
            S_SCAN: begin
                if (plat_hit && !hit_q) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end
                idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
            end
            S_DONE: begin
                collision_d     = hit_q;
                collision_idx_d = hit_idx_q;
                recycled_d      = rec_cnt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_q            <= 1'b0;
            fc_dly_q        <= 1'b0;
            idx_q           <= '0;
            scroll_q        <= '0;
            dx_q            <= '0;
            dy_q            <= '0;
            ds_q            <= '0;
            fall_q          <= 1'b0;
            lfsr_q          <= LFSR_SEED;
            rec_cnt_q       <= '0;
            hit_q           <= 1'b0;
            hit_idx_q       <= '0;
            collision_q     <= 1'b0;
            collision_idx_q <= '0;
            recycled_q      <= '0;
            overrun_q       <= 1'b0;
            for (int i = 0; i < N_PLAT; i++) begin
                x_q[i]     <= 9'((i * PLAT_STRIDE_X) % RANGE);
                y_q[i]     <= 9'(i * ROW_PITCH);
                color_q[i] <= '0;
            end
        end else begin
            fc_q            <= fc_d;
            fc_dly_q        <= fc_dly_d;
            idx_q           <= idx_d;
            scroll_q        <= scroll_d;
            dx_q            <= dx_d;
            dy_q            <= dy_d;
            ds_q            <= ds_d;
            fall_q          <= fall_d;
            lfsr_q          <= lfsr_d;
            rec_cnt_q       <= rec_cnt_d;
            hit_q           <= hit_d;
            hit_idx_q       <= hit_idx_d;
            collision_q     <= collision_d;
            collision_idx_q <= collision_idx_d;
            recycled_q      <= recycled_d;
            overrun_q       <= overrun_d;
            x_q             <= x_d;
            y_q             <= y_d;
            color_q         <= color_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_platform_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_platform_bank
// Function : Scoreboarded random and directed bench for platform_bank
// Revision : 1.0 - initial release
// ============================================================================
module tb_platform_bank;

    localparam int N      = 16;
    localparam int SH     = 480;
    localparam int RNG    = 288;
    localparam int PW     = 32;
    localparam int PH     = 8;
    localparam int BROKEN = 7;

    typedef struct {
        int col;
        int idx;
        int rec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_clk;
    logic [8:0] scroll;
    logic [9:0] doodle_x, doodle_y, doodle_size;
    logic       doodle_falling;
    logic [3:0] rd_idx;
    logic [8:0] rd_x, rd_y;
    logic [2:0] rd_color;
    logic       busy, frame_done, collision;
    logic [3:0] collision_idx;
    logic [4:0] recycled;
    logic       overrun;

    int          total, bad, done_cnt;
    exp_t        exp_q[$];
    int          mx[N], my[N], mc[N];
    logic [15:0] ml;

    always #5 clk = ~clk;

    platform_bank dut (
        .Clk            (clk),
        .Reset          (rst),
        .frame_clk      (frame_clk),
        .scroll         (scroll),
        .doodle_x       (doodle_x),
        .doodle_y       (doodle_y),
        .doodle_size    (doodle_size),
        .doodle_falling (doodle_falling),
        .rd_idx         (rd_idx),
        .rd_x           (rd_x),
        .rd_y           (rd_y),
        .rd_color       (rd_color),
        .busy           (busy),
        .frame_done     (frame_done),
        .collision      (collision),
        .collision_idx  (collision_idx),
        .recycled       (recycled),
        .overrun        (overrun)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = (i * 53) % RNG;
            my[i] = i * (SH / N);
            mc[i] = 0;
        end
        ml = 16'hACE1;
    endtask

    // Reference frame: move everything, recycle from the top, first falling landing wins.
    task automatic model_frame(input int sc, input int dx, input int dy, input int ds,
                               input bit fall, output int col, output int cidx, output int rec);
        int s, n9;
        if (sc > SH - 1) sc = SH - 1;
        rec = 0;
        for (int i = 0; i < N; i++) begin
            s = my[i] + sc;
            if (s >= SH) begin
                my[i] = s - SH;
                ml    = {1'b0, ml[15:1]} ^ (ml[0] ? 16'hB400 : 16'h0000);
                n9    = int'(ml[8:0]);
                mx[i] = (n9 < RNG) ? n9 : n9 - RNG;
                mc[i] = int'(ml[15:13]);
                rec++;
            end else begin
                my[i] = s;
            end
        end
        col  = 0;
        cidx = 0;
        for (int i = 0; i < N; i++) begin
            if (col == 0 && fall && mc[i] != BROKEN && dx < mx[i] + PW && dx + ds > mx[i]
                && my[i] <= dy + ds && dy + ds < my[i] + PH) begin
                col  = 1;
                cidx = i;
            end
        end
    endtask

    task automatic rd(input int i, output int x, output int y, output int c);
        rd_idx = 4'(i);
        #1;
        x = int'(rd_x);
        y = int'(rd_y);
        c = int'(rd_color);
    endtask

    task automatic check_array(input string tag);
        int x, y, c;
        for (int i = 0; i < N; i++) begin
            rd(i, x, y, c);
            chk($sformatf("%s_x%0d", tag, i), x, mx[i]);
            chk($sformatf("%s_y%0d", tag, i), y, my[i]);
            chk($sformatf("%s_c%0d", tag, i), c, mc[i]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    // mode 0: normal pass, 1: extra frame edge mid-pass, 2: reset during SCAN
    task automatic run_frame(input int sc, input int dx, input int dy, input int ds,
                             input bit fall, input int mode, input string tag);
        int col, cidx, rec, bcnt, d0;
        bit seen;
        @(posedge clk); #1;
        scroll         = 9'(sc);
        doodle_x       = 10'(dx);
        doodle_y       = 10'(dy);
        doodle_size    = 10'(ds);
        doodle_falling = fall;
        frame_clk      = 1'b1;
        model_frame(sc, dx, dy, ds, fall, col, cidx, rec);
        exp_q.push_back('{col, cidx, rec});
        bcnt = 0;
        seen = 1'b0;
        d0   = done_cnt;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin
                frame_clk      = 1'b0;
                scroll         = 9'($urandom);
                doodle_x       = 10'($urandom);
                doodle_y       = 10'($urandom);
                doodle_size    = 10'($urandom);
                doodle_falling = 1'($urandom);
            end
            if (busy) bcnt++;
            if (mode == 1 && bcnt == 10) frame_clk = 1'b1;
            if (mode == 1 && bcnt == 13) frame_clk = 1'b0;
            if (mode == 2 && bcnt == 20) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", int'(busy), 0);
                chk("abort_frame_done", int'(frame_done), 0);
                seen = 1'b1;
            end else if (frame_done) begin
                seen = 1'b1;
            end
        end
        if (mode == 2) begin
            repeat (40) @(negedge clk);
            chk("abort_no_done", done_cnt - d0, 0);
            exp_q.delete();
            model_reset();
            chk("abort_collision", int'(collision), 0);
            chk("abort_recycled", int'(recycled), 0);
            chk("abort_overrun", int'(overrun), 0);
            check_array("abort");
        end else begin
            chk({tag, "_done_seen"}, int'(seen), 1);
            chk({tag, "_busy_cycles"}, bcnt, 2 * N + 1);
            repeat (2) @(negedge clk);
            chk({tag, "_busy_low"}, int'(busy), 0);
            if (mode == 1) begin
                repeat (80) @(negedge clk);
                chk("overrun_done_count", done_cnt - d0, 1);
                chk("overrun_flag", int'(overrun), 1);
            end
            check_array(tag);
        end
    endtask

    // Scoreboard monitor: result registers settle the cycle after frame_done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_done) begin
                done_cnt++;
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_done: got frame_done expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_collision", int'(collision), e.col);
                    chk("sb_collision_idx", int'(collision_idx), e.idx);
                    chk("sb_recycled", int'(recycled), e.rec);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x, y, c, sc, j, py, dx, dy, ds;
        total = 0; bad = 0; done_cnt = 0;
        rst = 1'b1; frame_clk = 1'b0; scroll = '0;
        doodle_x = '0; doodle_y = '0; doodle_size = '0; doodle_falling = 1'b0; rd_idx = '0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_collision", int'(collision), 0);
        chk("rst_collision_idx", int'(collision_idx), 0);
        chk("rst_recycled", int'(recycled), 0);
        chk("rst_overrun", int'(overrun), 0);
        rd(1, x, y, c);
        chk("rst_p1_x", x, 53); chk("rst_p1_y", y, 30); chk("rst_p1_c", c, 0);
        rd(15, x, y, c);
        chk("rst_p15_x", x, 219); chk("rst_p15_y", y, 450); chk("rst_p15_c", c, 0);
        check_array("reset");

        run_frame(5, 0, 0, 0, 1'b0, 0, "plain");
        rd(15, x, y, c); chk("plain_p15_y", y, 455);
        rd(0, x, y, c);  chk("plain_p0_y", y, 5);
        chk("plain_recycled", int'(recycled), 0);

        do_reset();
        run_frame(35, 0, 0, 0, 1'b0, 0, "wrap");
        rd(15, x, y, c);
        chk("wrap_p15_x", x, 112); chk("wrap_p15_y", y, 5); chk("wrap_p15_c", c, 7);
        rd(14, x, y, c); chk("wrap_p14_y", y, 455);
        chk("wrap_recycled", int'(recycled), 1);
        run_frame(0, 112, 0, 8, 1'b1, 0, "broken");
        chk("broken_collision", int'(collision), 0);

        do_reset();
        run_frame(0, 60, 10, 20, 1'b1, 0, "land");
        chk("land_collision", int'(collision), 1);
        chk("land_idx", int'(collision_idx), 1);
        do_reset();
        run_frame(0, 60, 10, 20, 1'b0, 0, "rising");
        chk("rising_collision", int'(collision), 0);

        do_reset();
        run_frame(7, 60, 10, 20, 1'b1, 1, "ovr");
        run_frame(3, 0, 0, 0, 1'b0, 2, "abort");

        do_reset();
        for (int f = 0; f < 30; f++) begin
            sc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 12);
            j  = $urandom_range(0, N - 1);
            py = (my[j] + ((sc > SH - 1) ? SH - 1 : sc)) % SH;
            dx = mx[j] + $urandom_range(0, 50) - 20;
            if (dx < 0) dx = 0;
            ds = $urandom_range(1, 40);
            dy = py + $urandom_range(0, 9) - ds;
            if (dy < 0) dy = $urandom_range(0, 1023);
            run_frame(sc, dx, dy, ds, ($urandom_range(0, 3) != 0), 0, $sformatf("rand%0d", f));
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
